regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (WriteReg / WriteData / RegWrite, 16 x 20-bit registers, written on negedge clock) between two writeback requesters: A (ALU writeback) and B (memory/load writeback).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The oldest buffered write is issued first, which preserves write order to the same register.
- Exports a pending-write mask for the hazard unit.

Parameters:
- DATA_W, 20, register data width
- ADDR_W, 4, register index width
- NREGS, 16, number of registers (= 1<<ADDR_W)

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous; discards buffered (not yet issued) writes
- a_valid  input  1  requester A offers a write
- a_ready  output  1  A buffer can accept this cycle
- a_reg  input  ADDR_W  A destination register
- a_data  input  DATA_W  A write data
- b_valid  input  1  requester B offers a write
- b_ready  output  1  B buffer can accept this cycle
- b_reg  input  ADDR_W  B destination register
- b_data  input  DATA_W  B write data
- rf_RegWrite  output  1  write enable to the register file
- rf_WriteReg  output  ADDR_W  destination to the register file
- rf_WriteData  output  DATA_W  data to the register file
- busy_mask  output  NREGS  bit i = write to register i not yet committed
- grant_b  output  1  the issued write (rf_RegWrite=1) came from B

Behaviour:
- State:
  - Buffers bufA and bufB: valid, reg, data.
  - Age flag a_older.
  - Registered issue stage: rf_RegWrite, rf_WriteReg, rf_WriteData, grant_b.
- Grant (combinational from buffer state):
  - Only A valid -> A.
  - Only B valid -> B.
  - Both valid -> A if a_older, else B.
  - Neither valid -> none.
- Ready: a_ready = !bufA.valid | grantA; same form for B. A grant frees the slot in the same cycle, giving 1 write/cycle/requester when uncontended.
- Accept: on posedge with x_valid & x_ready, the buffer loads reg/data and becomes valid. With both valid, the buffer not granted holds.
- Age:
  - Loading A while B is already held and not granted -> a_older=0.
  - Loading B while A is held and not granted -> a_older=1.
  - Both load on the same edge (and neither remains held) -> a_older=1 (A first).
- Issue: on posedge with a grant:
  - rf_RegWrite<=1; rf_WriteReg/rf_WriteData <= the granted buffer's values.
  - grant_b <= (granted==B).
  - Granted buffer clears unless reloaded on the same edge.
  - No grant -> rf_RegWrite<=0; address/data/grant_b hold.
- Commit: the register file captures on the negedge following the issue edge. Latency from accept edge to commit is 1.5 cycles when uncontended.
- busy_mask = decode(bufA.reg)&bufA.valid | decode(bufB.reg)&bufB.valid | decode(rf_WriteReg)&rf_RegWrite.
- Same-register writes: both buffered writes are issued in age order, never merged or dropped, so the last-accepted value wins in the register file.
- Starvation bound: a buffered write is issued within 2 cycles of acceptance.
- flush:
  - Clears bufA.valid, bufB.valid; sets a_older=1.
  - Accepts nothing that cycle; a_ready=b_ready=0 while flush=1.
  - A write already in the issue stage still commits.
  - No grant is issued on a flush edge (rf_RegWrite<=0).
- reset (overrides flush):
  - Buffers invalid; a_older=1.
  - rf_RegWrite=0, rf_WriteReg=0, rf_WriteData=0, grant_b=0.
  - busy_mask=0; a_ready=b_ready=0 during reset.
  - Reset mid-operation drops all pending writes, including the issue stage.

Test Plan:
- Reset high 2 cycles with a_valid=1 -> all outputs 0, busy_mask=0, a_ready=0; no register written.
- A alone: a_reg=3, a_data=20'h00001 for 1 cycle -> next cycle rf_RegWrite=1, WriteReg=3, grant_b=0; register 3 reads 1 after the negedge; busy_mask bit 3 clears after.
- A and B valid the same cycle, both reg 5, A data=0x0000A, B data=0x0000B -> two consecutive issues A then B; register 5 ends 0x0000B; b_ready low exactly 1 cycle.
- B held, then A arrives; both continuously valid for 6 cycles, B reg 7, A reg 8 -> issues alternate B,A,B,A...; no requester waits >2 cycles.
- Both buffers full (regs 1, 2), flush=1 one cycle -> neither write commits; busy_mask=0 next cycle; an issue-stage write to reg 4 still commits.
- Reset asserted the cycle after accepting a write to reg 9 -> reg 9 is not written; rf_RegWrite=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: A (ALU writeback) and B (memory/load writeback). Each requester
// owns a one-entry holding buffer; the oldest buffered write is issued first,
// so two writes to the same register always land in acceptance order.
// The issue stage is registered on posedge; the register file captures it on
// the following negedge.
//
// Handshake: a transfer happens on a posedge where x_valid & x_ready are both
// high. x_ready never depends on x_valid, so a requester may wait on ready.
//
// Ports:
//   clock, reset      posedge clock; synchronous active-high reset
//   flush             discards buffered, not yet issued, writes
//   a_valid/a_ready/a_reg/a_data   requester A write offer
//   b_valid/b_ready/b_reg/b_data   requester B write offer
//   rf_RegWrite/rf_WriteReg/rf_WriteData   register-file write port
//   busy_mask         bit i set while a write to register i is uncommitted
//   grant_b           the issued write came from B

module regfile_write_arbiter #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_WriteReg,
    output logic [DATA_W-1:0] rf_WriteData,
    output logic [NREGS-1:0]  busy_mask,
    output logic              grant_b
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    // Holding buffers
    logic              bufa_valid, bufb_valid;
    logic [ADDR_W-1:0] bufa_reg, bufb_reg;
    logic [DATA_W-1:0] bufa_data, bufb_data;
    logic              a_older;

    // Issue stage
    logic              rf_we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_b_q;

    logic quiet;
    logic gnt_a, gnt_b;
    logic acc_a, acc_b;
    logic a_held, b_held;

    always_comb begin
        // Nothing is granted or accepted while reset or flush is active.
        quiet   = reset | flush;
        gnt_a   = !quiet & bufa_valid & (!bufb_valid | a_older);
        gnt_b   = !quiet & bufb_valid & (!bufa_valid | !a_older);
        // A granted slot is free again in the same cycle.
        a_ready = !quiet & (!bufa_valid | gnt_a);
        b_ready = !quiet & (!bufb_valid | gnt_b);
        acc_a   = a_valid & a_ready;
        acc_b   = b_valid & b_ready;
        // A buffer that stays occupied across this edge with its old write.
        a_held  = bufa_valid & !gnt_a;
        b_held  = bufb_valid & !gnt_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bufa_valid <= 1'b0;
            bufb_valid <= 1'b0;
            bufa_reg   <= '0;
            bufb_reg   <= '0;
            bufa_data  <= '0;
            bufb_data  <= '0;
            a_older    <= 1'b1;
            rf_we_q    <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            grant_b_q  <= 1'b0;
        end else if (flush) begin
            // The issue-stage write still commits on the negedge before this
            // edge; afterwards the port goes idle.
            bufa_valid <= 1'b0;
            bufb_valid <= 1'b0;
            a_older    <= 1'b1;
            rf_we_q    <= 1'b0;
        end else begin
            if (gnt_a) begin
                rf_we_q   <= 1'b1;
                wreg_q    <= bufa_reg;
                wdata_q   <= bufa_data;
                grant_b_q <= 1'b0;
            end else if (gnt_b) begin
                rf_we_q   <= 1'b1;
                wreg_q    <= bufb_reg;
                wdata_q   <= bufb_data;
                grant_b_q <= 1'b1;
            end else begin
                rf_we_q   <= 1'b0;
            end

            if (acc_a) begin
                bufa_valid <= 1'b1;
                bufa_reg   <= a_reg;
                bufa_data  <= a_data;
            end else if (gnt_a) begin
                bufa_valid <= 1'b0;
            end

            if (acc_b) begin
                bufb_valid <= 1'b1;
                bufb_reg   <= b_reg;
                bufb_data  <= b_data;
            end else if (gnt_b) begin
                bufb_valid <= 1'b0;
            end

            // Age tracks which occupied buffer was loaded first. A joint load
            // can only happen when neither old write stays, and A goes first.
            if (acc_a && acc_b) begin
                a_older <= 1'b1;
            end else if (acc_a && b_held) begin
                a_older <= 1'b0;
            end else if (acc_b && a_held) begin
                a_older <= 1'b1;
            end
        end
    end

    // Reset drops the issue-stage write immediately, before its negedge.
    assign rf_RegWrite  = rf_we_q & !reset;
    assign rf_WriteReg  = wreg_q;
    assign rf_WriteData = wdata_q;
    assign grant_b      = grant_b_q;

    always_comb begin
        busy_mask = '0;
        if (!reset) begin
            if (bufa_valid) busy_mask = busy_mask | (ONE << bufa_reg);
            if (bufb_valid) busy_mask = busy_mask | (ONE << bufb_reg);
            if (rf_we_q)    busy_mask = busy_mask | (ONE << wreg_q);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-capturing register
// file model attached to the write port.

module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_reg;
    logic [19:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_reg;
    logic [19:0] b_data;
    logic        rf_RegWrite;
    logic [3:0]  rf_WriteReg;
    logic [19:0] rf_WriteData;
    logic [15:0] busy_mask;
    logic        grant_b;

    logic [19:0] rf_mem [16];

    int checks;
    int failures;

    regfile_write_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .rf_RegWrite  (rf_RegWrite),
        .rf_WriteReg  (rf_WriteReg),
        .rf_WriteData (rf_WriteData),
        .busy_mask    (busy_mask),
        .grant_b      (grant_b)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file: captures on the negedge following the issue edge.
    always @(negedge clock) begin
        if (rf_RegWrite === 1'b1) rf_mem[rf_WriteReg] <= rf_WriteData;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        reset   = 1'b1;
        flush   = 1'b0;
        a_valid = 1'b1;
        a_reg   = 4'd3;
        a_data  = 20'h00001;
        b_valid = 1'b0;
        b_reg   = '0;
        b_data  = '0;

        // Reset held two cycles with a_valid high
        tick();
        chk("rst1_we", 32'(rf_RegWrite), 32'd0);
        chk("rst1_busy", 32'(busy_mask), 32'd0);
        chk("rst1_aready", 32'(a_ready), 32'd0);
        tick();
        chk("rst2_we", 32'(rf_RegWrite), 32'd0);
        chk("rst2_wreg", 32'(rf_WriteReg), 32'd0);
        chk("rst2_wdata", 32'(rf_WriteData), 32'd0);
        chk("rst2_grantb", 32'(grant_b), 32'd0);
        chk("rst2_busy", 32'(busy_mask), 32'd0);
        chk("rst2_aready", 32'(a_ready), 32'd0);
        chk("rst2_bready", 32'(b_ready), 32'd0);
        chk("rst2_mem3", 32'(rf_mem[3]), 32'd0);

        // A alone: reg 3 <= 1
        reset = 1'b0;
        #1;
        chk("a1_aready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("a1_busy_buf", 32'(busy_mask), 32'h0008);
        chk("a1_we_pre", 32'(rf_RegWrite), 32'd0);
        tick();
        chk("a1_we", 32'(rf_RegWrite), 32'd1);
        chk("a1_wreg", 32'(rf_WriteReg), 32'd3);
        chk("a1_wdata", 32'(rf_WriteData), 32'h00001);
        chk("a1_grantb", 32'(grant_b), 32'd0);
        chk("a1_busy_iss", 32'(busy_mask), 32'h0008);
        chk("a1_mem3_pre", 32'(rf_mem[3]), 32'd0);
        #5;
        chk("a1_mem3", 32'(rf_mem[3]), 32'h00001);
        tick();
        chk("a1_we_after", 32'(rf_RegWrite), 32'd0);
        chk("a1_busy_after", 32'(busy_mask), 32'd0);

        // A and B together, both to reg 5: A then B, B's value wins
        a_valid = 1'b1; a_reg = 4'd5; a_data = 20'h0000A;
        b_valid = 1'b1; b_reg = 4'd5; b_data = 20'h0000B;
        #1;
        chk("s5_aready0", 32'(a_ready), 32'd1);
        chk("s5_bready0", 32'(b_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("s5_bready1", 32'(b_ready), 32'd0);
        chk("s5_aready1", 32'(a_ready), 32'd1);
        chk("s5_busy", 32'(busy_mask), 32'h0020);
        tick();
        chk("s5_iss1_wdata", 32'(rf_WriteData), 32'h0000A);
        chk("s5_iss1_grantb", 32'(grant_b), 32'd0);
        chk("s5_iss1_wreg", 32'(rf_WriteReg), 32'd5);
        chk("s5_bready2", 32'(b_ready), 32'd1);
        #5;
        chk("s5_mem_a", 32'(rf_mem[5]), 32'h0000A);
        tick();
        chk("s5_iss2_we", 32'(rf_RegWrite), 32'd1);
        chk("s5_iss2_wdata", 32'(rf_WriteData), 32'h0000B);
        chk("s5_iss2_grantb", 32'(grant_b), 32'd1);
        chk("s5_bready3", 32'(b_ready), 32'd1);
        #5;
        chk("s5_mem_b", 32'(rf_mem[5]), 32'h0000B);
        tick();
        chk("s5_we_after", 32'(rf_RegWrite), 32'd0);

        // B held, then A arrives; both stay valid: issues alternate B,A,...
        b_valid = 1'b1; b_reg = 4'd7; b_data = 20'h00077;
        tick();
        a_valid = 1'b1; a_reg = 4'd8; a_data = 20'h00088;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("alt%0d_we", i), 32'(rf_RegWrite), 32'd1);
            chk($sformatf("alt%0d_grantb", i), 32'(grant_b), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_wreg", i), 32'(rf_WriteReg), (i % 2 == 0) ? 32'd7 : 32'd8);
            if (i == 5) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
        tick();
        chk("alt_we_after", 32'(rf_RegWrite), 32'd0);
        chk("alt_busy_after", 32'(busy_mask), 32'd0);
        chk("alt_mem7", 32'(rf_mem[7]), 32'h00077);
        chk("alt_mem8", 32'(rf_mem[8]), 32'h00088);

        // Flush with both buffers full (regs 1, 2) and reg 4 in issue stage
        a_valid = 1'b1; a_reg = 4'd4; a_data = 20'h00044;
        b_valid = 1'b1; b_reg = 4'd2; b_data = 20'h00022;
        tick();
        a_reg = 4'd1; a_data = 20'h00011;
        b_valid = 1'b0;
        #1;
        chk("fl_aready_pre", 32'(a_ready), 32'd1);
        chk("fl_bready_pre", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        flush   = 1'b1;
        #1;
        chk("fl_aready", 32'(a_ready), 32'd0);
        chk("fl_bready", 32'(b_ready), 32'd0);
        chk("fl_we", 32'(rf_RegWrite), 32'd1);
        chk("fl_wreg", 32'(rf_WriteReg), 32'd4);
        chk("fl_busy", 32'(busy_mask), 32'h0016);
        #5;
        chk("fl_mem4", 32'(rf_mem[4]), 32'h00044);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_busy_after", 32'(busy_mask), 32'd0);
        chk("fl_we_after", 32'(rf_RegWrite), 32'd0);
        chk("fl_wreg_hold", 32'(rf_WriteReg), 32'd4);
        tick();
        tick();
        chk("fl_mem1", 32'(rf_mem[1]), 32'd0);
        chk("fl_mem2", 32'(rf_mem[2]), 32'd0);
        chk("fl_we_idle", 32'(rf_RegWrite), 32'd0);

        // Reset right after accepting a write to reg 9
        a_valid = 1'b1; a_reg = 4'd9; a_data = 20'h00099;
        tick();
        a_valid = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rm_we", 32'(rf_RegWrite), 32'd0);
        chk("rm_busy", 32'(busy_mask), 32'd0);
        chk("rm_aready", 32'(a_ready), 32'd0);
        tick();
        reset = 1'b0;
        chk("rm_we_edge", 32'(rf_RegWrite), 32'd0);
        chk("rm_wreg", 32'(rf_WriteReg), 32'd0);
        tick();
        tick();
        chk("rm_mem9", 32'(rf_mem[9]), 32'd0);
        chk("rm_we_after", 32'(rf_RegWrite), 32'd0);
        chk("rm_busy_after", 32'(busy_mask), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
